// File: rtl/pattern_seq_gen.sv
// WIDTH-bit pattern sequencer: rotate, shift-reload, ping-pong and count modes, advanced by step pulses or a run-mode tick.
// Optional wrap event counter output wrap_cnt is enabled by defining PATTERN_SEQ_WRAP_CNT_EN.
module pattern_seq_gen #(
  parameter int WIDTH = 4,
  parameter int DIV   = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             run,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] seq,
`ifdef PATTERN_SEQ_WRAP_CNT_EN
  output logic [15:0]      wrap_cnt,
`endif
  output logic             wrap
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_ROTATE   = 2'b00,
    MODE_SHIFT    = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_COUNT    = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             adv;
  logic             pp_dir;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt_seq;
  logic             nxt_pp;
  logic             nxt_wrap;
  logic             flip;
  logic             rot_dir;

  assign mode_sel  = mode_e'(mode);
  assign tick      = run && (tick_cnt == CNT_MAX);
  assign adv       = step || tick;
  assign rot_left  = {seq[WIDTH-2:0], seq[WIDTH-1]};
  assign rot_right = {seq[0], seq[WIDTH-1:1]};

  // Prescaler is held at zero while stopped so the first tick lands DIV cycles after run rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!run || tick_cnt == CNT_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_seq  = seq;
    nxt_pp   = pp_dir;
    nxt_wrap = 1'b0;
    shifted  = '0;
    flip     = 1'b0;
    rot_dir  = pp_dir;
    case (mode_sel)
      MODE_ROTATE: begin
        if (dir) begin
          nxt_seq  = rot_left;
          nxt_wrap = seq[WIDTH-1];
        end else begin
          nxt_seq  = rot_right;
          nxt_wrap = seq[0];
        end
      end
      MODE_SHIFT: begin
        shifted = dir ? {seq[WIDTH-2:0], 1'b0} : {1'b0, seq[WIDTH-1:1]};
        if (shifted == '0) begin
          nxt_seq  = data;
          nxt_wrap = 1'b1;
        end else begin
          nxt_seq = shifted;
        end
      end
      MODE_PINGPONG: begin
        // Reverse before moving when the leading end bit is already set.
        if (seq != '0) begin
          flip     = pp_dir ? seq[WIDTH-1] : seq[0];
          rot_dir  = pp_dir ^ flip;
          nxt_pp   = rot_dir;
          nxt_wrap = flip;
          nxt_seq  = rot_dir ? rot_left : rot_right;
        end
      end
      MODE_COUNT: begin
        if (dir) begin
          nxt_seq  = seq + WIDTH'(1);
          nxt_wrap = &seq;
        end else begin
          nxt_seq  = seq - WIDTH'(1);
          nxt_wrap = (seq == '0);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq    <= WIDTH'(1);
      pp_dir <= 1'b1;
      wrap   <= 1'b0;
    end else if (load) begin
      seq    <= data;
      pp_dir <= dir;
      wrap   <= 1'b0;
    end else if (adv) begin
      seq    <= nxt_seq;
      pp_dir <= nxt_pp;
      wrap   <= nxt_wrap;
    end else begin
      wrap   <= 1'b0;
    end
  end

`ifdef PATTERN_SEQ_WRAP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= '0;
    end else if (load) begin
      wrap_cnt <= '0;
    end else if (adv && nxt_wrap && wrap_cnt != 16'hFFFF) begin
      wrap_cnt <= wrap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen (WIDTH=4, DIV=4): stimulus queues expected {seq,wrap},
// a negedge monitor pops and compares whenever seq changes or wrap pulses.
module tb_pattern_seq_gen;

  logic       clk;
  logic       rst;
  logic       load;
  logic       step;
  logic       run;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] data;
  logic [3:0] seq;
  logic       wrap;
`ifdef PATTERN_SEQ_WRAP_CNT_EN
  logic [15:0] wrap_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];
  logic [3:0] prev_seq;

  pattern_seq_gen #(.WIDTH(4), .DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .run  (run),
    .dir  (dir),
    .mode (mode),
    .data (data),
    .seq  (seq),
`ifdef PATTERN_SEQ_WRAP_CNT_EN
    .wrap_cnt (wrap_cnt),
`endif
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle stimulus; starts and ends 1ns after a rising edge.
  task automatic applyStimulus(input logic l, input logic s, input logic [1:0] m, input logic d,
                               input logic [3:0] dat, input logic [3:0] exp_seq, input logic exp_wrap);
    load = l;
    step = s;
    mode = m;
    dir  = d;
    data = dat;
    sb.push_back({exp_seq, exp_wrap});
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      prev_seq = seq;
    end else if (seq !== prev_seq || wrap !== 1'b0) begin
      prev_seq = seq;
      if (sb.size() == 0) begin
        checkOutput("unexpected_update", {27'd0, seq, wrap}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_seq", {28'd0, seq}, {28'd0, e[4:1]});
        checkOutput("sb_wrap", {31'd0, wrap}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; step = 1'b0; run = 1'b0; dir = 1'b1; mode = 2'b00; data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_seq", {28'd0, seq}, 32'h1);
    checkOutput("reset_wrap", {31'd0, wrap}, 32'h0);
    rst = 1'b0;

    // rotate left x4, then one rotate right
    applyStimulus(0, 1, 2'b00, 1, 4'h0, 4'b0010, 0);
    applyStimulus(0, 1, 2'b00, 1, 4'h0, 4'b0100, 0);
    applyStimulus(0, 1, 2'b00, 1, 4'h0, 4'b1000, 0);
    applyStimulus(0, 1, 2'b00, 1, 4'h0, 4'b0001, 1);
    applyStimulus(0, 1, 2'b00, 0, 4'h0, 4'b1000, 1);

    // shift-reload right, then left
    applyStimulus(1, 0, 2'b01, 0, 4'b1100, 4'b1100, 0);
    applyStimulus(0, 1, 2'b01, 0, 4'b1100, 4'b0110, 0);
    applyStimulus(0, 1, 2'b01, 0, 4'b1100, 4'b0011, 0);
    applyStimulus(0, 1, 2'b01, 0, 4'b1100, 4'b0001, 0);
    applyStimulus(0, 1, 2'b01, 0, 4'b1100, 4'b1100, 1);
    applyStimulus(1, 0, 2'b01, 1, 4'b0011, 4'b0011, 0);
    applyStimulus(0, 1, 2'b01, 1, 4'b0011, 4'b0110, 0);
    applyStimulus(0, 1, 2'b01, 1, 4'b0011, 4'b1100, 0);
    applyStimulus(0, 1, 2'b01, 1, 4'b0011, 4'b1000, 0);
    applyStimulus(0, 1, 2'b01, 1, 4'b0011, 4'b0011, 1);

    // ping-pong; dir input ignored except on load
    applyStimulus(1, 0, 2'b10, 1, 4'b0001, 4'b0001, 0);
    applyStimulus(0, 1, 2'b10, 0, 4'h0, 4'b0010, 0);
    applyStimulus(0, 1, 2'b10, 0, 4'h0, 4'b0100, 0);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b1000, 0);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b0100, 1);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b0010, 0);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b0001, 0);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b0010, 1);
    applyStimulus(1, 0, 2'b10, 1, 4'b1001, 4'b1001, 0);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b1100, 1);
    applyStimulus(0, 1, 2'b10, 1, 4'h0, 4'b0110, 0);

    // mode change keeps pattern and ping-pong direction
    applyStimulus(0, 1, 2'b00, 0, 4'h0, 4'b0011, 0);
    applyStimulus(0, 1, 2'b10, 0, 4'h0, 4'b0110, 1);

    // count down through zero, then run-mode ticks
    applyStimulus(1, 0, 2'b11, 0, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 1, 2'b11, 0, 4'h0, 4'b1111, 1);
    sb.push_back({4'b1110, 1'b0});
    sb.push_back({4'b1101, 1'b0});
    sb.push_back({4'b1100, 1'b0});
    run = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    run = 1'b0;
    checkOutput("run_12_cycles", {28'd0, seq}, 32'hC);

    // count up through all-ones
    applyStimulus(1, 0, 2'b11, 1, 4'b1111, 4'b1111, 0);
    applyStimulus(0, 1, 2'b11, 1, 4'h0, 4'b0000, 1);
    applyStimulus(0, 1, 2'b11, 1, 4'h0, 4'b0001, 0);

    // load wins over step
    applyStimulus(1, 1, 2'b11, 1, 4'b1010, 4'b1010, 0);

    // step coincident with tick gives one advance
    sb.push_back({4'b1011, 1'b0});
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    run  = 1'b0;
    checkOutput("step_plus_tick", {28'd0, seq}, 32'hB);

    // asynchronous reset mid-run at count 2
    run = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_seq", {28'd0, seq}, 32'h1);
    checkOutput("async_rst_wrap", {31'd0, wrap}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back({4'b0010, 1'b0});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_no_tick", {28'd0, seq}, 32'h1);
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    checkOutput("post_rst_first_tick", {28'd0, seq}, 32'h2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
